// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin whole-frame arbiter sharing one UART transmitter.
// Ports: clock/reset, per-requester req/done/start_in/data_in, uart_ocupado in;
// iniciar_envio/dado_saida to the UART, grant, ocupado_req, timeout_flag out.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   done,
    input  logic [NUM_REQ-1:0]   start_in,
    input  logic [NUM_REQ*8-1:0] data_in,
    input  logic                 uart_ocupado,
    output logic                 iniciar_envio,
    output logic [7:0]           dado_saida,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   ocupado_req,
    output logic                 timeout_flag
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DRAIN,
        GAP
    } state_t;

    state_t               state;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        winner;
    logic [PW-1:0]        cand;
    logic [NUM_REQ-1:0]   win_oh;
    logic [WW-1:0]        wd_cnt;
    logic [GW-1:0]        gap_cnt;
    logic                 pend;
    logic                 ini_q;
    logic [7:0]           own_byte;
    logic                 fwd;
    logic                 own_done;
    logic                 own_drop;
    logic                 wd_hit;
    logic                 release_now;
    logic                 timeout_now;
    logic                 busy;
    int                   idx;

    // Scan downward so the closest set bit at or above rr_ptr wins last.
    always_comb begin
        winner = rr_ptr;
        cand   = '0;
        idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = PW'(idx);
            if (req[cand]) winner = cand;
        end
    end

    assign win_oh = NUM_REQ'(1) << winner;

    // grant is one-hot in GRANT and zero elsewhere, so it doubles as the
    // owner select and gates all owner-side inputs outside GRANT.
    always_comb begin
        own_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) own_byte = own_byte | data_in[i*8 +: 8];
        end
    end

    assign fwd      = |(start_in & grant);
    assign own_done = |(done & grant);
    assign own_drop = ~|(req & grant);
    assign wd_hit   = (wd_cnt == WD_LAST);

    // A start in the same cycle as the limit clears the watchdog instead.
    assign timeout_now = wd_hit & ~fwd & ~own_done & ~own_drop;
    assign release_now = own_done | own_drop | timeout_now;

    // pend and iniciar_envio cover the gap until the UART raises its busy.
    assign busy = uart_ocupado | pend | iniciar_envio;

    assign ocupado_req = (state == GRANT) ?
        (~grant | {NUM_REQ{busy}}) : '1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            wd_cnt        <= '0;
            gap_cnt       <= '0;
            pend          <= 1'b0;
            ini_q         <= 1'b0;
            iniciar_envio <= 1'b0;
            dado_saida    <= 8'h00;
            timeout_flag  <= 1'b0;
        end else begin
            iniciar_envio <= 1'b0;
            timeout_flag  <= 1'b0;
            ini_q         <= iniciar_envio;

            if (fwd) pend <= 1'b1;
            else if (ini_q) pend <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (|req) begin
                        grant  <= win_oh;
                        rr_ptr <= (winner == PTR_LAST) ?
                                  '0 : winner + 1'b1;
                        wd_cnt <= '0;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (fwd) begin
                        iniciar_envio <= 1'b1;
                        dado_saida    <= own_byte;
                        wd_cnt        <= '0;
                    end else if (!wd_hit) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    if (release_now) begin
                        grant        <= '0;
                        timeout_flag <= timeout_now;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!uart_ocupado && !pend) begin
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (uart_ocupado) gap_cnt <= '0;
                    else if (gap_cnt == GAP_LAST) state <= IDLE;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed + randomized bench for uart_tx_arbiter.
// Expected grants come from a round-robin pick model; timing from gap arithmetic.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N   = 2;
    localparam int GAP = 8;
    localparam int TO  = 50;
    localparam int DW  = N * 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  done = '0;
    logic [N-1:0]  start_in = '0;
    logic [DW-1:0] data_in = '0;
    logic          uart_ocupado = 1'b0;
    logic          iniciar_envio;
    logic [7:0]    dado_saida;
    logic [N-1:0]  grant;
    logic [N-1:0]  ocupado_req;
    logic          timeout_flag;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr   = 0;
    int cur   = 0;
    logic [7:0] last_byte = 8'h00;

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .done(done),
        .start_in(start_in),
        .data_in(data_in),
        .uart_ocupado(uart_ocupado),
        .iniciar_envio(iniciar_envio),
        .dado_saida(dado_saida),
        .grant(grant),
        .ocupado_req(ocupado_req),
        .timeout_flag(timeout_flag)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First set request at or after pointer p, wrapping around.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clock) begin
        if (reset) check("onehot0", 32'($onehot0(grant)), 1);
    end

    task automatic wait_grant(input string tag, input int exp_n,
                              input int w);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (grant == '0 && n < 200);
        check({tag, "_delay"}, n, exp_n);
        check({tag, "_grant"}, 32'(grant), 1 << w);
        ptr = (w + 1) % N;
        cur = w;
    endtask

    task automatic send(input int g, input logic [7:0] b);
        start_in = '0;
        start_in[g] = 1'b1;
        data_in = DW'($urandom);
        data_in[g*8 +: 8] = b;
        cyc();
        check("fwd_pulse", 32'(iniciar_envio), 1);
        check("fwd_byte", 32'(dado_saida), 32'(b));
        check("mask_t1", 32'(ocupado_req), 3);
        start_in = '0;
        data_in = DW'($urandom);
        cyc();
        check("fwd_low", 32'(iniciar_envio), 0);
        check("hold_byte", 32'(dado_saida), 32'(b));
        check("mask_t2", 32'(ocupado_req), 3);
        cyc();
        check("mask_idle", 32'(ocupado_req), 3 & ~(1 << g));
        last_byte = b;
    endtask

    task automatic ignore(input int g);
        start_in = '0;
        start_in[(g + 1) % N] = 1'b1;
        data_in = DW'($urandom);
        cyc();
        start_in = '0;
        check("ignore_pulse", 32'(iniciar_envio), 0);
        check("ignore_byte", 32'(dado_saida), 32'(last_byte));
    endtask

    task automatic done_pulse(input int g);
        done = '0;
        done[g] = 1'b1;
        cyc();
        done = '0;
    endtask

    initial begin
        int n;
        int k;
        int b;
        logic [N-1:0] m;

        repeat (3) cyc();
        check("rst_ini", 32'(iniciar_envio), 0);
        check("rst_dado", 32'(dado_saida), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_tmo", 32'(timeout_flag), 0);
        check("rst_mask", 32'(ocupado_req), 3);
        reset = 1'b1;

        req = 2'b01;
        wait_grant("single", 1, pick(req, ptr));
        check("own_mask", 32'(ocupado_req), 2);
        send(0, 8'hAD);
        send(0, 8'h01);
        send(0, 8'h02);
        ignore(0);
        done_pulse(0);
        check("rel_grant", 32'(grant), 0);
        check("rel_mask", 32'(ocupado_req), 3);
        wait_grant("regap", GAP + 2, pick(req, ptr));

        start_in = 2'b01;
        data_in = DW'($urandom);
        cyc();
        check("pre_rst_ini", 32'(iniciar_envio), 1);
        reset = 1'b0;
        start_in = '0;
        #1;
        check("mid_rst_ini", 32'(iniciar_envio), 0);
        check("mid_rst_grant", 32'(grant), 0);
        check("mid_rst_dado", 32'(dado_saida), 0);
        cyc();
        reset = 1'b1;
        ptr = 0;
        req = 2'b11;
        wait_grant("post_rst", 1, pick(req, ptr));

        send(0, 8'($urandom));
        done_pulse(0);
        wait_grant("rr1", GAP + 2, pick(req, ptr));
        check("nonowner_mask", 32'(ocupado_req), 1);
        send(1, 8'($urandom));
        done_pulse(1);
        wait_grant("rr2", GAP + 2, pick(req, ptr));

        req = 2'b10;
        done_pulse(0);
        wait_grant("wd_grant", GAP + 2, pick(req, ptr));
        n = 0;
        do begin
            cyc();
            n++;
        end while (!timeout_flag && n < 200);
        check("wd_delay", n, TO);
        check("wd_grant0", 32'(grant), 0);
        check("wd_mask", 32'(ocupado_req), 3);
        cyc();
        check("wd_once", 32'(timeout_flag), 0);
        wait_grant("wd_regrant", GAP + 1, pick(req, ptr));

        req = 2'b01;
        wait_grant("drop", GAP + 3, pick(req, ptr));

        uart_ocupado = 1'b1;
        #1;
        check("busy_mask", 32'(ocupado_req), 3);
        done_pulse(0);
        for (int i = 0; i < 29; i++) begin
            cyc();
            check("busy_hold", 32'(grant), 0);
        end
        uart_ocupado = 1'b0;
        wait_grant("busy_rel", GAP + 2, pick(req, ptr));

        k = $urandom_range(0, GAP - 1);
        b = $urandom_range(1, 5);
        done_pulse(0);
        cyc();
        repeat (k) cyc();
        uart_ocupado = 1'b1;
        repeat (b) cyc();
        uart_ocupado = 1'b0;
        wait_grant("gap_rst", GAP + 1, pick(req, ptr));

        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) send(cur, 8'($urandom));
            if ($urandom_range(0, 1) == 1) ignore(cur);
            m = N'($urandom_range(1, 3));
            req = m;
            done_pulse(cur);
            wait_grant("rand", GAP + 2, pick(m, ptr));
        end

        req = '0;
        repeat (4) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ frame producers, e.g. several payload senders for board state, game status and events.
- Grants whole frames with round-robin fairness, so bytes from different frames never interleave on the line.
- Forwards the granted producer's start pulse and byte to the UART, and returns a per-requester busy view.
- Enforces a minimum idle gap between frames and a watchdog on stalled grants.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- GAP_CYCLES, 100: idle clocks required between frames, counted only while the UART is idle.
- TIMEOUT_CYCLES, 2000000: clocks a grant may go without a start pulse before it is revoked.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-low (0 = reset).
- req  in  NUM_REQ  level per requester; held high for the whole frame.
- done  in  NUM_REQ  1-cycle end-of-frame pulse per requester.
- start_in  in  NUM_REQ  per-requester byte start pulse.
- data_in  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
- uart_ocupado  in  1  UART transmitter busy.
- iniciar_envio  out  1  start pulse to the UART.
- dado_saida  out  8  byte to the UART.
- grant  out  NUM_REQ  one-hot current owner; all zero when there is no owner.
- ocupado_req  out  NUM_REQ  busy view returned to each requester.
- timeout_flag  out  1  1-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset (reset=0):
  - iniciar_envio=0, dado_saida=8'h00, grant=0, timeout_flag=0.
  - rr_ptr=0, counters=0, state=IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no further start pulse is emitted.
- States: IDLE, GRANT, DRAIN, GAP.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching upward from rr_ptr, wrapping at NUM_REQ.
  - Next cycle: grant=onehot(winner), rr_ptr<=(winner+1) mod NUM_REQ, watchdog cleared, state=GRANT.
  - A requester that raises req while another holds the grant waits; the winner is decided only in IDLE.
- GRANT, forwarding from owner g:
  - When start_in[g]=1, the next cycle has iniciar_envio=1 and dado_saida=data_in[g]. Latency is exactly 1 cycle.
  - iniciar_envio is otherwise 0. dado_saida holds its last value.
  - start_in from non-owners is ignored.
  - pend flag: set on a forwarded start_in[g], cleared the cycle after iniciar_envio is issued.
- ocupado_req:
  - For the owner: uart_ocupado OR pend OR iniciar_envio. This hides the 1-cycle forwarding latency, so the requester never sees a false idle right after its own start.
  - For every non-owner: constant 1.
  - In DRAIN, GAP and IDLE all bits are 1.
- Release from GRANT:
  - Triggered by done[g]=1, or req[g]=0, or the watchdog reaching TIMEOUT_CYCLES-1.
  - The watchdog counts every GRANT cycle and clears on each forwarded start.
  - On release: grant<=0, state=DRAIN.
  - On a watchdog release only, timeout_flag=1 for one cycle.
- Same-cycle start_in[g] and done[g]: the byte is still forwarded, then release occurs.
- DRAIN: wait until uart_ocupado=0 and pend=0, then clear gap_cnt and go to GAP.
- GAP:
  - gap_cnt increments while uart_ocupado=0 and resets to 0 if uart_ocupado=1.
  - When gap_cnt=GAP_CYCLES-1, state=IDLE.
  - With GAP_CYCLES=0, the block goes straight from DRAIN to IDLE.
- Counter widths come from clog2 of their limits; no wrap is possible because every counter saturates at its limit.
- grant is always one-hot or zero; two owners at once is an error condition the bench must check.

Test Plan:
- Single requester: req[0]=1, three start_in pulses with bytes AD,01,02, then done[0].
  - Required: iniciar_envio one cycle after each start with dado_saida AD,01,02.
  - grant=01 during the frame; next grant possible no earlier than GAP_CYCLES idle clocks after done.
- Contention: req=11 from reset.
  - Required: grant=01 first; after done[0], grant=10; after done[1] with req=11 still held, grant=01 again (round-robin).
- Busy masking: owner pulses start_in while uart_ocupado=0.
  - Required: ocupado_req[g]=1 on the next two cycles, before uart_ocupado rises.
  - The non-owner bit of ocupado_req stays 1 throughout.
- Watchdog: TIMEOUT_CYCLES=50, req[1]=1 with no start pulses.
  - Required: 50 cycles after grant, timeout_flag pulses once, grant=0, state=DRAIN.
- Release while UART busy: done[0] pulses while uart_ocupado=1 for 30 cycles.
  - Required: no grant until those 30 cycles plus GAP_CYCLES idle cycles have elapsed.
- Reset mid-frame: reset=0 for 1 cycle during GRANT after a start pulse.
  - Required: iniciar_envio=0 and grant=0 immediately; after reset releases, the first grant goes to req[0] (rr_ptr=0).
